// File: rtl/mw_stage.sv
// mw_stage
// Memory stage of the five-stage MIPS pipeline. Takes the E/M register
// outputs, performs the data-memory access and registers the results into
// the M/W pipeline boundary. The data memory array is held here, and this
// block is the only writer of it.
//
// Ports:
//   Clk      in   clock, all state updates on posedge
//   Reset    in   synchronous, active-high; clears outputs and memory
//   Instr_M  in   [31:0] instruction in M stage (opcode in [31:26])
//   A3M      in   [4:0]  destination register in M stage
//   PC_M     in   [31:0] PC of the M-stage instruction
//   ALUoutM  in   [31:0] ALU result, used as byte address for loads/stores
//   RD2M     in   [31:0] store data (already forwarded upstream)
//   Instr_W  out  [31:0] registered Instr_M
//   A3W      out  [4:0]  registered A3M
//   PC_W     out  [31:0] registered PC_M
//   ALUoutW  out  [31:0] registered ALUoutM
//   DMoutW   out  [31:0] registered, extended load data (0 for non-loads)
//
// Optional feature: define DM_WRITE_LOG_EN to print one line per committed
// store ("@<pc>: *<word addr> <= <merged word>"). Without it the block
// produces no simulation output.
module mw_stage #(
    parameter int DM_WORDS = 4096,
    parameter int DM_AW    = 12
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr_M,
    input  logic [4:0]  A3M,
    input  logic [31:0] PC_M,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] RD2M,
    output logic [31:0] Instr_W,
    output logic [4:0]  A3W,
    output logic [31:0] PC_W,
    output logic [31:0] ALUoutW,
    output logic [31:0] DMoutW
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    logic [31:0] dm [DM_WORDS];

    logic [5:0]       opcode;
    logic [DM_AW-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [31:0]      wr_word;
    logic             is_store;

    // Address decode: upper address bits are dropped, so accesses wrap
    // modulo the memory size. No alignment checking is done.
    always_comb begin
        opcode   = Instr_M[31:26];
        word_idx = ALUoutM[DM_AW+1:2];
        rd_word  = dm[word_idx];

        case (ALUoutM[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase

        // Halfword ops look only at address bit 1.
        rd_half = ALUoutM[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Load extension. Stores and non-memory ops register zero.
    always_comb begin
        case (opcode)
            OP_LW:   load_data = rd_word;
            OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_data = {16'h0000, rd_half};
            OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_data = {24'h000000, rd_byte};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store merge: read-modify-write of the addressed word, replacing only
    // the lanes the store covers.
    always_comb begin
        wr_word  = rd_word;
        is_store = 1'b0;
        case (opcode)
            OP_SW: begin
                is_store = 1'b1;
                wr_word  = RD2M;
            end
            OP_SH: begin
                is_store = 1'b1;
                if (ALUoutM[1]) begin
                    wr_word[31:16] = RD2M[15:0];
                end else begin
                    wr_word[15:0]  = RD2M[15:0];
                end
            end
            OP_SB: begin
                is_store = 1'b1;
                case (ALUoutM[1:0])
                    2'd0:    wr_word[7:0]   = RD2M[7:0];
                    2'd1:    wr_word[15:8]  = RD2M[7:0];
                    2'd2:    wr_word[23:16] = RD2M[7:0];
                    default: wr_word[31:24] = RD2M[7:0];
                endcase
            end
            default: begin
                is_store = 1'b0;
            end
        endcase
    end

    // Memory and M/W registers. Reset wins over a store in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm[i] <= 32'h0000_0000;
            end
            Instr_W <= 32'h0000_0000;
            A3W     <= 5'd0;
            PC_W    <= 32'h0000_0000;
            ALUoutW <= 32'h0000_0000;
            DMoutW  <= 32'h0000_0000;
        end else begin
            if (is_store) begin
                dm[word_idx] <= wr_word;
            end
            Instr_W <= Instr_M;
            A3W     <= A3M;
            PC_W    <= PC_M;
            ALUoutW <= ALUoutM;
            DMoutW  <= load_data;
        end
    end

`ifdef DM_WRITE_LOG_EN
    // Write log: reports the full word as it will be after this store.
    always @(posedge Clk) begin
        if (!Reset && is_store) begin
            $display("@%h: *%h <= %h", PC_M, {ALUoutM[31:2], 2'b00}, wr_word);
        end
    end
`else
`endif

endmodule

// File: tb/tb_mw_stage.sv
module tb_mw_stage;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] LH   = 6'b100001;
    localparam logic [5:0] LHU  = 6'b100101;
    localparam logic [5:0] LB   = 6'b100000;
    localparam logic [5:0] LBU  = 6'b100100;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] SH   = 6'b101001;
    localparam logic [5:0] SB   = 6'b101000;
    localparam logic [5:0] ADDU = 6'b000000;
    localparam logic [5:0] ORI  = 6'b001101;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr_M;
    logic [4:0]  A3M;
    logic [31:0] PC_M;
    logic [31:0] ALUoutM;
    logic [31:0] RD2M;
    logic [31:0] Instr_W;
    logic [4:0]  A3W;
    logic [31:0] PC_W;
    logic [31:0] ALUoutW;
    logic [31:0] DMoutW;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  a3;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] dm;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    logic [31:0] pc;

    // Byte-granular reference memory (little-endian), 16 KiB wrap.
    logic [7:0] mb [int];

    mw_stage dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Instr_M (Instr_M),
        .A3M     (A3M),
        .PC_M    (PC_M),
        .ALUoutM (ALUoutM),
        .RD2M    (RD2M),
        .Instr_W (Instr_W),
        .A3W     (A3W),
        .PC_W    (PC_W),
        .ALUoutW (ALUoutW),
        .DMoutW  (DMoutW)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] get_b(input int a);
        int k;
        k = a & 16'h3FFF;
        return mb.exists(k) ? mb[k] : 8'h00;
    endfunction

    task automatic put_b(input int a, input logic [7:0] v);
        mb[a & 16'h3FFF] = v;
    endtask

    function automatic logic is_load(input logic [5:0] op);
        return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
        int a;
        logic [15:0] h;
        logic [7:0]  b;
        a = int'(addr[13:0]);
        b = get_b(a);
        h = {get_b((a & ~1) + 1), get_b(a & ~1)};
        case (op)
            LW:      return {get_b((a & ~3) + 3), get_b((a & ~3) + 2),
                             get_b((a & ~3) + 1), get_b(a & ~3)};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'h0, b};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] d);
        int a;
        a = int'(addr[13:0]);
        if (op == SW) begin
            put_b((a & ~3) + 0, d[7:0]);
            put_b((a & ~3) + 1, d[15:8]);
            put_b((a & ~3) + 2, d[23:16]);
            put_b((a & ~3) + 3, d[31:24]);
        end else if (op == SH) begin
            put_b((a & ~1) + 0, d[7:0]);
            put_b((a & ~1) + 1, d[15:8]);
        end else if (op == SB) begin
            put_b(a, d[7:0]);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL queue_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        cmp("Instr_W", Instr_W, e.instr);
        cmp("A3W", {27'h0, A3W}, {27'h0, e.a3});
        cmp("PC_W", PC_W, e.pc);
        cmp("ALUoutW", ALUoutW, e.alu);
        cmp("DMoutW", DMoutW, e.dm);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_dm);
        logic [25:0] lo;
        exp_t e;
        lo      = 26'($urandom());
        Instr_M = {op, lo};
        A3M     = 5'($urandom_range(0, 31));
        PC_M    = pc;
        pc      = pc + 32'd4;
        ALUoutM = addr;
        RD2M    = data;
        e.instr = Instr_M;
        e.a3    = A3M;
        e.pc    = PC_M;
        e.alu   = addr;
        e.dm    = exp_dm;
        exp_q.push_back(e);
        model_store(op, addr, data);
        @(posedge Clk);
        #1;
        check_out();
    endtask

    // One reset cycle with the given op on the inputs; it must be discarded.
    task automatic drive_reset(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
        Reset   = 1'b1;
        Instr_M = {op, 26'h0};
        A3M     = 5'd7;
        PC_M    = pc;
        ALUoutM = addr;
        RD2M    = data;
        exp_q.push_back('0);
        mb.delete();
        @(posedge Clk);
        #1;
        check_out();
        Reset = 1'b0;
    endtask

    logic [5:0] op_tab [10] = '{LW, LH, LHU, LB, LBU, SW, SH, SB, ADDU, ORI};

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        total = 0;
        bad   = 0;
        pc    = 32'h0040_0000;
        Reset = 1'b0;
        Instr_M = '0; A3M = '0; PC_M = '0; ALUoutM = '0; RD2M = '0;

        // Reset then idle
        drive_reset(ADDU, 32'h0, 32'h0);
        drive(LW, 32'h0000_0010, 32'h0, 32'h0000_0000);

        // Word store then load
        drive(SW, 32'h0000_0008, 32'h1234_5678, 32'h0);
        drive(LW, 32'h0000_0008, 32'h0, 32'h1234_5678);

        // Byte store into lane 3, signed/unsigned byte loads
        drive(SB,  32'h0000_000B, 32'h0000_00AB, 32'h0);
        drive(LB,  32'h0000_000B, 32'h0, 32'hFFFF_FFAB);
        drive(LBU, 32'h0000_000B, 32'h0, 32'h0000_00AB);
        drive(LW,  32'h0000_0008, 32'h0, 32'hAB34_5678);

        // Upper halfword store, signed/unsigned halfword loads
        drive(SH,  32'h0000_0022, 32'h0000_8001, 32'h0);
        drive(LH,  32'h0000_0022, 32'h0, 32'hFFFF_8001);
        drive(LHU, 32'h0000_0022, 32'h0, 32'h0000_8001);
        drive(LHU, 32'h0000_0023, 32'h0, 32'h0000_8001);
        drive(LW,  32'h0000_0020, 32'h0, 32'h8001_0000);

        // Address wrap
        drive(SW, 32'h0000_4004, 32'hDEAD_BEEF, 32'h0);
        drive(LW, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF);

        // Non-memory op: no write, DMoutW zero
        drive(ADDU, 32'h0000_0055, 32'hFFFF_FFFF, 32'h0);
        drive(LW,   32'h0000_0054, 32'h0, 32'h0000_0000);

        // Reset coincident with a store: store discarded, memory cleared
        drive_reset(SW, 32'h0000_0000, 32'h1111_1111);
        drive(LW, 32'h0000_0000, 32'h0, 32'h0000_0000);
        drive(LW, 32'h0000_0008, 32'h0, 32'h0000_0000);

        // Random traffic over a small window, with random upper address bits
        for (int i = 0; i < 60; i++) begin
            op   = op_tab[$urandom_range(0, 9)];
            addr = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 31));
            data = $urandom();
            drive(op, addr, data, is_load(op) ? model_load(op, addr) : 32'h0);
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL queue_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
